vga_draw_scheduler: RTL
=======================

// Module: vga_draw_scheduler
// PURPOSE
// Shares the single VGA plot port (160x120, 3-bit colour) among NUM_REQ sprite
// owners (player, aliens, bullets). Grants one owner at a time, round-robin,
// and scans its SPR_W x SPR_H box pixel by pixel onto the plot bus. Also runs
// a full-screen black clear on request. Sits between game objects and the VGA adapter.
// PARAMETERS
// NUM_REQ     4    number of requesters (2..8)
// SPR_W_LOG2  2    log2 sprite width in pixels (4)
// SPR_H_LOG2  2    log2 sprite height in pixels (4)
// X_MAX       159  last visible column
// Y_MAX       119  last visible row
// PORTS
// clk         in   1            system clock
// reset_n     in   1            synchronous, active-low reset
// req         in   NUM_REQ      per-owner draw request, level; hold until done
// req_x       in   NUM_REQ*8    owner i top-left x in bits [8i+7:8i]
// req_y       in   NUM_REQ*7    owner i top-left y in bits [7i+6:7i]
// req_colour  in   NUM_REQ*3    owner i colour (000 = erase)
// clear_req   in   1            one-cycle pulse: request full-screen clear
// grant       out  NUM_REQ      one-hot, high while owner's box is scanned
// done        out  NUM_REQ      one-hot, 1-cycle pulse at end of owner's box
// clear_done  out  1            1-cycle pulse at end of clear
// busy        out  1            state != IDLE
// vga_x       out  8            plot x (registered)
// vga_y       out  7            plot y (registered)
// vga_colour  out  3            plot colour (registered)
// vga_plot    out  1            plot write enable (registered)
// BEHAVIOUR
// - Reset: state IDLE; grant, done, clear_done, busy, vga_* all 0; rr pointer
//   = NUM_REQ-1 (so owner 0 wins first); clear_pending = 0. Reset mid-scan aborts, no done.
// - States: IDLE, DRAW, DRAW_DONE, CLEAR, CLEAR_DONE.
// - clear_req pulse sets sticky clear_pending in any state; cleared on entering CLEAR.
// - IDLE: clear_pending -> CLEAR (priority over req); else any req -> DRAW with
//   winner = first set req searching from ptr+1 mod NUM_REQ; latch winner's
//   x/y/colour; ptr <= winner; pixel counter k <= 0; grant[winner] <= 1.
// - DRAW: k = 0..SPR_W*SPR_H-1, one per cycle; px = x0 + k[SPR_W_LOG2-1:0],
//   py = y0 + k[upper bits]. Sums taken one bit wider than x/y; pixel with
//   px>X_MAX or py>Y_MAX is clipped (vga_plot 0 that cycle, still counted).
//   Latched values used throughout; req drop or input change mid-scan ignored.
// - k = last -> DRAW_DONE: grant <= 0, done[winner] <= 1 for one cycle -> IDLE.
// - Timing, req seen at edge N in IDLE: grant high N+1..N+16; pixel k on
//   vga_* at cycle N+2+k; done pulse cycle N+17 (with last pixel); IDLE N+18;
//   earliest next grant N+19. Back-to-back owners: 18-cycle period.
// - CLEAR: cx 0..X_MAX inner, cy 0..Y_MAX outer, colour 000, vga_plot 1,
//   same 1-cycle output latency; 19200 pixels; then CLEAR_DONE: clear_done
//   pulse 1 cycle -> IDLE. Requests wait (no grant) during clear.
// - vga_plot 0 in IDLE/DONE states except the trailing last-pixel cycle.
// - No two grant bits ever high; done only for a granted owner.
// STRUCTURE
// - Shared package vga_pkg: SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7,
//   COLOUR_W=3, COLOUR_BLACK=3'b000, scheduler state encoding.
// - Sub-module rr_arbiter (req, ptr -> one-hot winner + index, any_req),
//   combinational; FSM, counters, latches, output register in this module.
// TESTING
// - req=0001, x=78,y=100,c=111 -> 16 plots (78..81,100..103) cycles N+2..N+17, done[0] at N+17.
// - req=1111 held -> grants 0,1,2,3,0 in order, 18-cycle spacing, one-hot always.
// - req[2], x=158,y=118 -> only 4 plots (158..159,118..119); 16 scan cycles; done[2].
// - clear_req during owner 1 scan -> owner 1 completes, then 19200 black plots,
//   last (159,119); clear_done; pending req[0] granted after.
// - reset_n low at pixel 7 of a scan -> next cycle all outputs 0, no done; next grant owner 0.
// - req[3] dropped after 2 cycles of grant -> scan still 16 pixels with latched coords, done[3].

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA plot-port definitions: screen geometry, field widths, scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAW       = 3'd1,
    ST_DRAW_DONE  = 3'd2,
    ST_CLEAR      = 3'd3,
    ST_CLEAR_DONE = 3'd4
  } sched_state_t;

  // Box origin and colour latched from the granted owner.
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } sprite_t;

  // One registered write onto the VGA adapter plot bus.
  typedef struct packed {
    logic                plot;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } plot_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request searching upward from ptr+1 (wrapping).
// Latency: combinational.
// Backpressure: none; caller samples the result when it is ready to grant.
// Ports:
//   req        - request vector, one bit per owner
//   ptr        - index of the previously granted owner
//   win_onehot - one-hot winner (all zero when no request)
//   win_idx    - binary index of the winner
//   any_req    - at least one request asserted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // ptr itself is visited last, so the previous winner has lowest priority.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found            = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/vga_draw_scheduler.sv
// Shares the VGA plot port among NUM_REQ sprite owners (round-robin box scan) plus a full-screen clear.
// Latency: grant 1 cycle after req seen in IDLE; each scanned pixel reaches vga_* one cycle later.
// Backpressure: req is level and waits (no grant) while another box or a clear is in progress.
// Ports:
//   clk, reset_n                  - clock, synchronous active-low reset
//   req / req_x / req_y / req_colour - per-owner request and packed box origin/colour
//   clear_req                     - pulse: schedule a full-screen black clear
//   grant / done                  - one-hot owner being scanned / end-of-box pulse
//   clear_done, busy              - end-of-clear pulse, scheduler not idle
//   vga_x / vga_y / vga_colour / vga_plot - registered plot bus
module vga_draw_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SPR_W_LOG2 = 2,
  parameter int SPR_H_LOG2 = 2,
  parameter int X_MAX      = SCREEN_W - 1,
  parameter int Y_MAX      = SCREEN_H - 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  input  logic                         clear_req,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         clear_done,
  output logic                         busy,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int K_W   = SPR_W_LOG2 + SPR_H_LOG2;

  localparam logic [X_W:0]   X_LIM   = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   Y_LIM   = (Y_W+1)'(Y_MAX);
  localparam logic [X_W-1:0] CX_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] CY_LAST = Y_W'(Y_MAX);
  localparam logic [K_W-1:0] K_LAST  = '1;

  sched_state_t state, state_nxt;

  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [K_W-1:0]     k, k_nxt;
  logic [X_W-1:0]     cx, cx_nxt;
  logic [Y_W-1:0]     cy, cy_nxt;
  sprite_t            spr, spr_nxt;
  logic               clear_pending, clear_pending_nxt;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt;
  logic               clear_done_nxt;
  plot_t              plot_q, plot_nxt;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [X_W-1:0]      own_x      [NUM_REQ];
  logic [Y_W-1:0]      own_y      [NUM_REQ];
  logic [COLOUR_W-1:0] own_colour [NUM_REQ];

  logic [X_W:0] px_sum;
  logic [Y_W:0] py_sum;
  logic         px_in, py_in;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_own
    assign own_x[gi]      = req_x[gi*X_W +: X_W];
    assign own_y[gi]      = req_y[gi*Y_W +: Y_W];
    assign own_colour[gi] = req_colour[gi*COLOUR_W +: COLOUR_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx),
    .any_req    (arb_any)
  );

  // Low k bits walk across the row, high bits walk down. Sums are one bit
  // wider so a box hanging off the right/bottom edge clips instead of wrapping.
  assign px_sum = {1'b0, spr.x} + (X_W+1)'(k[SPR_W_LOG2-1:0]);
  assign py_sum = {1'b0, spr.y} + (Y_W+1)'(k[K_W-1:SPR_W_LOG2]);
  assign px_in  = (px_sum <= X_LIM);
  assign py_in  = (py_sum <= Y_LIM);

  always_comb begin
    state_nxt         = state;
    ptr_nxt           = ptr;
    k_nxt             = k;
    cx_nxt            = cx;
    cy_nxt            = cy;
    spr_nxt           = spr;
    grant_nxt         = grant;
    done_nxt          = '0;
    clear_done_nxt    = 1'b0;
    plot_nxt          = '0;
    clear_pending_nxt = clear_pending | clear_req;

    case (state)
      ST_IDLE: begin
        if (clear_pending) begin
          state_nxt         = ST_CLEAR;
          cx_nxt            = '0;
          cy_nxt            = '0;
          // A fresh pulse on the same edge schedules another clear.
          clear_pending_nxt = clear_req;
        end else if (arb_any) begin
          state_nxt      = ST_DRAW;
          ptr_nxt        = arb_idx;
          k_nxt          = '0;
          grant_nxt      = arb_onehot;
          spr_nxt.x      = own_x[arb_idx];
          spr_nxt.y      = own_y[arb_idx];
          spr_nxt.colour = own_colour[arb_idx];
        end
      end

      ST_DRAW: begin
        plot_nxt.plot   = px_in && py_in;
        plot_nxt.x      = px_sum[X_W-1:0];
        plot_nxt.y      = py_sum[Y_W-1:0];
        plot_nxt.colour = spr.colour;
        if (k == K_LAST) begin
          state_nxt = ST_DRAW_DONE;
          grant_nxt = '0;
          done_nxt  = grant;
        end else begin
          k_nxt = k + K_W'(1);
        end
      end

      ST_DRAW_DONE: begin
        state_nxt = ST_IDLE;
      end

      ST_CLEAR: begin
        plot_nxt.plot   = 1'b1;
        plot_nxt.x      = cx;
        plot_nxt.y      = cy;
        plot_nxt.colour = COLOUR_BLACK;
        if (cx == CX_LAST) begin
          cx_nxt = '0;
          if (cy == CY_LAST) begin
            state_nxt      = ST_CLEAR_DONE;
            clear_done_nxt = 1'b1;
          end else begin
            cy_nxt = cy + Y_W'(1);
          end
        end else begin
          cx_nxt = cx + X_W'(1);
        end
      end

      ST_CLEAR_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr           <= IDX_W'(NUM_REQ - 1);
      k             <= '0;
      cx            <= '0;
      cy            <= '0;
      spr           <= '0;
      clear_pending <= 1'b0;
      grant         <= '0;
      done          <= '0;
      clear_done    <= 1'b0;
      plot_q        <= '0;
    end else begin
      ptr           <= ptr_nxt;
      k             <= k_nxt;
      cx            <= cx_nxt;
      cy            <= cy_nxt;
      spr           <= spr_nxt;
      clear_pending <= clear_pending_nxt;
      grant         <= grant_nxt;
      done          <= done_nxt;
      clear_done    <= clear_done_nxt;
      plot_q        <= plot_nxt;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign vga_x      = plot_q.x;
  assign vga_y      = plot_q.y;
  assign vga_colour = plot_q.colour;
  assign vga_plot   = plot_q.plot;

endmodule
